// File: rtl/ac_motor_svpwm_pkg.sv
// Shared types and constants for the SVPWM sequencer slice.
package ac_motor_svpwm_pkg;

    // Phase within one centre-aligned PWM period: leading zero, low vector,
    // high vector, trailing zero.
    typedef enum logic [1:0] {
        PH_ZERO_A = 2'd0,
        PH_LOW    = 2'd1,
        PH_HIGH   = 2'd2,
        PH_ZERO_B = 2'd3
    } phase_t;

    // Highest legal sector number; 6 and 7 are rejected at shadow load.
    localparam int SECTOR_MAX = 5;

    // Default width of the period counter and of the dwell inputs.
    localparam int CNT_W_DEFAULT = 16;

endpackage

// File: rtl/ac_motor_svpwm_dwell_clamp.sv
// Combinational dwell clamp: limits the low/high dwell times so they fit in
// one PWM period and splits the leftover zero time around them.
// All arithmetic is one bit wider than the inputs so tl+th never wraps.
module ac_motor_svpwm_dwell_clamp
    import ac_motor_svpwm_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int PERIOD = 1000
) (
    input  logic [CNT_W-1:0] t_low,
    input  logic [CNT_W-1:0] t_high,
    output logic [CNT_W:0]   tl,
    output logic [CNT_W:0]   th,
    output logic [CNT_W:0]   t0a,
    output logic             sat
);

    localparam logic [CNT_W:0] PERIOD_X = (CNT_W + 1)'(PERIOD);

    logic [CNT_W:0] low_x;
    logic [CNT_W:0] high_x;
    logic [CNT_W:0] room_x;
    logic [CNT_W:0] t0_x;

    // Clamp low first, then high into whatever room is left; leading zero is the floor half.
    always_comb begin
        low_x  = {1'b0, t_low};
        high_x = {1'b0, t_high};
        tl     = (low_x > PERIOD_X) ? PERIOD_X : low_x;
        room_x = PERIOD_X - tl;
        th     = (high_x > room_x) ? room_x : high_x;
        t0_x   = room_x - th;
        t0a    = t0_x >> 1;
        sat    = (low_x > PERIOD_X) || (high_x > room_x);
    end

endmodule

// File: rtl/ac_motor_svpwm_sequencer.sv
// SVPWM period sequencer: runs the period counter, holds shadow copies of the
// sector and clamped dwell times, and emits registered one-hot phase strobes
// (U_0 / U_LOW / U_HIGH) for the downstream switch controller.
//
// Handshake: none. Inputs are sampled level-wise; they only take effect at a
// shadow load (every disabled cycle, and on the enabled edge that wraps the
// counter to 0), so mid-period changes appear at the next CNT==0.
module ac_motor_svpwm_sequencer
    import ac_motor_svpwm_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEFAULT,
    parameter int PERIOD = 1000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ENABLE,
    input  logic [2:0]       SECTOR_IN,
    input  logic [CNT_W-1:0] T_LOW,
    input  logic [CNT_W-1:0] T_HIGH,
    output logic [2:0]       SECTOR,
    output logic             U_0,
    output logic             U_LOW,
    output logic             U_HIGH,
    output logic             PERIOD_START,
    output logic             SAT,
    output logic             SECTOR_ERR,
    output phase_t           PHASE_DBG
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             load;

    logic [CNT_W:0]   tl_q;
    logic [CNT_W:0]   th_q;
    logic [CNT_W:0]   t0a_q;

    logic [CNT_W:0]   c_tl;
    logic [CNT_W:0]   c_th;
    logic [CNT_W:0]   c_t0a;
    logic             c_sat;

    logic [CNT_W:0]   tl_e;
    logic [CNT_W:0]   th_e;
    logic [CNT_W:0]   t0a_e;

    phase_t           phase_q;
    phase_t           phase_next;

    ac_motor_svpwm_dwell_clamp #(
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD)
    ) u_clamp (
        .t_low  (T_LOW),
        .t_high (T_HIGH),
        .tl     (c_tl),
        .th     (c_th),
        .t0a    (c_t0a),
        .sat    (c_sat)
    );

    // Counter advance and shadow-load decision for the coming edge.
    always_comb begin
        load     = !ENABLE || (cnt == CNT_LAST);
        cnt_next = '0;
        if (ENABLE && (cnt != CNT_LAST)) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // Dwell values that will be in force once the counter reaches cnt_next.
    always_comb begin
        tl_e  = load ? c_tl  : tl_q;
        th_e  = load ? c_th  : th_q;
        t0a_e = load ? c_t0a : t0a_q;
    end

    // Next-phase decode: the phase of cnt_next under the effective shadows.
    // Empty phases fall through naturally because their bounds coincide.
    always_comb begin
        logic [CNT_W:0] k;
        logic [CNT_W:0] b_low;
        logic [CNT_W:0] b_high;
        logic [CNT_W:0] b_tail;
        k          = {1'b0, cnt_next};
        b_low      = t0a_e;
        b_high     = t0a_e + tl_e;
        b_tail     = t0a_e + tl_e + th_e;
        phase_next = PH_ZERO_A;
        if (ENABLE) begin
            if (k < b_low) begin
                phase_next = PH_ZERO_A;
            end else if (k < b_high) begin
                phase_next = PH_LOW;
            end else if (k < b_tail) begin
                phase_next = PH_HIGH;
            end else begin
                phase_next = PH_ZERO_B;
            end
        end
    end

    // Counter and shadow registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt        <= '0;
            tl_q       <= '0;
            th_q       <= '0;
            t0a_q      <= '0;
            SECTOR     <= 3'd0;
            SAT        <= 1'b0;
            SECTOR_ERR <= 1'b0;
        end else begin
            cnt <= cnt_next;
            if (load) begin
                tl_q  <= c_tl;
                th_q  <= c_th;
                t0a_q <= c_t0a;
                SAT   <= c_sat;
                if (SECTOR_IN <= 3'(SECTOR_MAX)) begin
                    SECTOR     <= SECTOR_IN;
                    SECTOR_ERR <= 1'b0;
                end else begin
                    SECTOR_ERR <= 1'b1;
                end
            end
        end
    end

    // Phase state and glitch-free registered one-hot strobes.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            phase_q      <= PH_ZERO_A;
            U_0          <= 1'b1;
            U_LOW        <= 1'b0;
            U_HIGH       <= 1'b0;
            PERIOD_START <= 1'b0;
        end else begin
            phase_q      <= phase_next;
            U_0          <= (phase_next == PH_ZERO_A) || (phase_next == PH_ZERO_B);
            U_LOW        <= (phase_next == PH_LOW);
            U_HIGH       <= (phase_next == PH_HIGH);
            PERIOD_START <= ENABLE && (cnt == CNT_LAST);
        end
    end

    assign PHASE_DBG = phase_q;

endmodule

// File: tb/tb_ac_motor_svpwm_sequencer.sv
// Testbench for ac_motor_svpwm_sequencer with PERIOD=20.
module tb_ac_motor_svpwm_sequencer;
    import ac_motor_svpwm_pkg::*;

    localparam int CNT_W  = 16;
    localparam int PERIOD = 20;

    // ---------------- clock / reset / DUT ----------------
    logic             CLK = 1'b0;
    logic             RESET;
    logic             ENABLE;
    logic [2:0]       SECTOR_IN;
    logic [CNT_W-1:0] T_LOW;
    logic [CNT_W-1:0] T_HIGH;
    logic [2:0]       SECTOR;
    logic             U_0;
    logic             U_LOW;
    logic             U_HIGH;
    logic             PERIOD_START;
    logic             SAT;
    logic             SECTOR_ERR;
    phase_t           PHASE_DBG;

    always #5 CLK = ~CLK;

    ac_motor_svpwm_sequencer #(
        .CNT_W  (CNT_W),
        .PERIOD (PERIOD)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .ENABLE       (ENABLE),
        .SECTOR_IN    (SECTOR_IN),
        .T_LOW        (T_LOW),
        .T_HIGH       (T_HIGH),
        .SECTOR       (SECTOR),
        .U_0          (U_0),
        .U_LOW        (U_LOW),
        .U_HIGH       (U_HIGH),
        .PERIOD_START (PERIOD_START),
        .SAT          (SAT),
        .SECTOR_ERR   (SECTOR_ERR),
        .PHASE_DBG    (PHASE_DBG)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- reference model ----------------
    // Per-period schedule as a plain array of phase codes: 0 zero, 1 low, 2 high.
    int m_sched[PERIOD];
    int m_cnt;
    bit m_en;
    int m_sector;
    bit m_sat;
    bit m_err;

    task automatic model_reset();
        for (int i = 0; i < PERIOD; i++) m_sched[i] = 0;
        m_cnt    = 0;
        m_en     = 1'b0;
        m_sector = 0;
        m_sat    = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic model_load(input int tl_in, input int th_in, input int sec);
        int tl;
        int th;
        int t0a;
        int idx;
        tl    = (tl_in > PERIOD) ? PERIOD : tl_in;
        th    = (th_in > PERIOD - tl) ? PERIOD - tl : th_in;
        m_sat = (tl_in > PERIOD) || (th_in > PERIOD - tl);
        t0a   = (PERIOD - tl - th) / 2;
        idx   = 0;
        for (int i = 0; i < t0a; i++) begin m_sched[idx] = 0; idx++; end
        for (int i = 0; i < tl; i++)  begin m_sched[idx] = 1; idx++; end
        for (int i = 0; i < th; i++)  begin m_sched[idx] = 2; idx++; end
        while (idx < PERIOD) begin m_sched[idx] = 0; idx++; end
        if (sec <= SECTOR_MAX) begin
            m_sector = sec;
            m_err    = 1'b0;
        end else begin
            m_err = 1'b1;
        end
    endtask

    function automatic logic [15:0] model_expect();
        int ph;
        ph = m_en ? m_sched[m_cnt] : 0;
        return {7'd0, 3'(m_sector), ph == 0, ph == 1, ph == 2,
                m_en && (m_cnt == 0), m_sat, m_err};
    endfunction

    function automatic logic [15:0] dut_out();
        return {7'd0, SECTOR, U_0, U_LOW, U_HIGH, PERIOD_START, SAT, SECTOR_ERR};
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0t cnt=%0d: got %b expected %b", name, $time, m_cnt, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called away from the clock edge; applies inputs, clocks once, then checks.
    task automatic step(input bit en, input int sec, input int tl, input int th);
        bit load;
        ENABLE    = en;
        SECTOR_IN = 3'(sec);
        T_LOW     = CNT_W'(tl);
        T_HIGH    = CNT_W'(th);
        @(posedge CLK);
        #1;
        load = !en || (m_cnt == PERIOD - 1);
        if (load) model_load(tl, th, sec);
        m_cnt = en ? (m_cnt + 1) % PERIOD : 0;
        m_en  = en;
        check("model", dut_out(), model_expect());
        check("onehot", {15'd0, $onehot({U_0, U_LOW, U_HIGH})}, 16'd1);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic async_reset();
        #2;
        RESET = 1'b1;
        #1;
        model_reset();
        check("async_reset", dut_out(), 16'b0000000_000_100_000);
        #2;
        RESET = 1'b0;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int tl;
        int th;
        int sec;
        int low_at;
        int high_at;
        int tail_at;
        bit sat;
    } dir_t;

    dir_t tab[7];

    initial begin
        int tl_r;
        int th_r;
        int sec_r;
        int ps_count;
        logic [2:0] exp_u;

        tab[0] = '{tl: 6,  th: 4,  sec: 2, low_at: 5,  high_at: 11, tail_at: 15, sat: 1'b0};
        tab[1] = '{tl: 5,  th: 4,  sec: 1, low_at: 5,  high_at: 10, tail_at: 14, sat: 1'b0};
        tab[2] = '{tl: 15, th: 10, sec: 0, low_at: 0,  high_at: 15, tail_at: 20, sat: 1'b1};
        tab[3] = '{tl: 0,  th: 0,  sec: 3, low_at: 10, high_at: 10, tail_at: 10, sat: 1'b0};
        tab[4] = '{tl: 25, th: 3,  sec: 4, low_at: 0,  high_at: 20, tail_at: 20, sat: 1'b1};
        tab[5] = '{tl: 0,  th: 20, sec: 5, low_at: 0,  high_at: 0,  tail_at: 20, sat: 1'b0};
        tab[6] = '{tl: 1,  th: 0,  sec: 0, low_at: 9,  high_at: 10, tail_at: 10, sat: 1'b0};

        // Reset state.
        RESET     = 1'b1;
        ENABLE    = 1'b0;
        SECTOR_IN = 3'd0;
        T_LOW     = '0;
        T_HIGH    = '0;
        model_reset();
        #8;
        check("reset_state", dut_out(), 16'b0000000_000_100_000);
        RESET = 1'b0;

        // Table-driven phase boundaries over two full periods each.
        foreach (tab[r]) begin
            step(1'b0, tab[r].sec, tab[r].tl, tab[r].th);
            for (int c = 0; c < 2 * PERIOD; c++) begin
                step(1'b1, tab[r].sec, tab[r].tl, tab[r].th);
                if (m_cnt < tab[r].low_at)       exp_u = 3'b100;
                else if (m_cnt < tab[r].high_at) exp_u = 3'b010;
                else if (m_cnt < tab[r].tail_at) exp_u = 3'b001;
                else                             exp_u = 3'b100;
                check("table_phase", {13'd0, U_0, U_LOW, U_HIGH}, {13'd0, exp_u});
                check("table_sec_sat", {12'd0, SECTOR, SAT}, {12'd0, 3'(tab[r].sec), tab[r].sat});
            end
        end

        // Sector change mid-period, then an illegal sector.
        for (int i = 0; i < PERIOD && m_cnt != PERIOD - 1; i++) step(1'b1, 1, 6, 4);
        step(1'b1, 1, 6, 4);
        for (int i = 0; i < PERIOD && m_cnt != 7; i++) step(1'b1, 1, 6, 4);
        for (int i = 0; i < PERIOD && m_cnt != PERIOD - 1; i++) begin
            step(1'b1, 3, 6, 4);
            check("sector_hold", {13'd0, SECTOR}, 16'd1);
        end
        step(1'b1, 3, 6, 4);
        check("sector_new", {13'd0, SECTOR}, 16'd3);
        for (int i = 0; i < PERIOD; i++) step(1'b1, 6, 6, 4);
        check("sector_err", {12'd0, SECTOR, SECTOR_ERR}, {12'd0, 3'd3, 1'b1});

        // Asynchronous reset at CNT=12, then counter restarts from 0.
        for (int i = 0; i < PERIOD && m_cnt != 12; i++) step(1'b1, 2, 6, 4);
        async_reset();
        for (int i = 0; i < PERIOD - 1; i++) step(1'b1, 2, 6, 4);
        check("restart_no_ps", {15'd0, PERIOD_START}, 16'd0);
        step(1'b1, 2, 6, 4);
        check("restart_ps", {15'd0, PERIOD_START}, 16'd1);

        // Disable at CNT=8, then re-enable and count period starts.
        for (int i = 0; i < PERIOD && m_cnt != 8; i++) step(1'b1, 2, 6, 4);
        step(1'b0, 2, 6, 4);
        check("disable_zero", {13'd0, U_0, U_LOW, U_HIGH}, 16'b100);
        step(1'b0, 2, 6, 4);
        ps_count = 0;
        for (int i = 1; i <= 3 * PERIOD; i++) begin
            step(1'b1, 2, 6, 4);
            if (PERIOD_START) ps_count++;
            check("ps_position", {15'd0, PERIOD_START}, {15'd0, (i % PERIOD) == 0});
        end
        check("ps_count", 16'(ps_count), 16'd3);

        // Randomized stimulus against the model.
        tl_r  = 6;
        th_r  = 4;
        sec_r = 2;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                tl_r  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535))
                                                    : int'($urandom_range(0, 24));
                th_r  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 65535))
                                                    : int'($urandom_range(0, 24));
                sec_r = int'($urandom_range(0, 7));
            end
            step($urandom_range(0, 19) != 0, sec_r, tl_r, th_r);
            if ($urandom_range(0, 199) == 0) async_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
